// File: rtl/spm_dp.sv
// ============================================================================
// Module   : spm_dp
// Brief    : Dual-port 32-bit scratchpad (IF + MEM ports) with byte-enable
//            writes, registered reads, MEM-priority write arbitration and a
//            hardware clear sweep after reset.
//            Optional macro SPM_FWD_EN: a same-index write-vs-read collision
//            returns the merged (new) word instead of the old word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spm_dp #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_,
  // IF port
  input  logic [31:0] if_spm_addr,
  input  logic        if_spm_as_,
  input  logic        if_spm_rw,
  input  logic [3:0]  if_spm_be,
  input  logic [31:0] if_spm_wr_data,
  output logic        if_spm_rdy,
  output logic [31:0] if_spm_rd_data,
  output logic        if_spm_rd_vld,
  output logic        if_spm_err,
  // MEM port
  input  logic [31:0] mem_spm_addr,
  input  logic        mem_spm_as_,
  input  logic        mem_spm_rw,
  input  logic [3:0]  mem_spm_be,
  input  logic [31:0] mem_spm_wr_data,
  output logic        mem_spm_rdy,
  output logic [31:0] mem_spm_rd_data,
  output logic        mem_spm_rd_vld,
  output logic        mem_spm_err,
  output logic        spm_init_done
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic [31:0]      mem_q [DEPTH];

  logic [31:0] if_rd_data_q,  mem_rd_data_q;
  logic        if_rd_vld_q,   mem_rd_vld_q;
  logic        if_err_q,      mem_err_q;
  logic        init_done_q;

  // Merge new bytes into an old word; be[b] selects bits [8b+7:8b]
  function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // ---------------- address decode ----------------
  logic [IDX_W-1:0] if_idx, mem_idx;
  logic             if_req, mem_req, if_bad, mem_bad, run, same_idx;
  logic             if_wr_ok, mem_wr_ok, if_stall;
  logic             if_we, if_re, if_er, mem_we, mem_re, mem_er;

  assign if_idx   = if_spm_addr[IDX_W+1:2];
  assign mem_idx  = mem_spm_addr[IDX_W+1:2];
  assign if_req   = ~if_spm_as_;
  assign mem_req  = ~mem_spm_as_;
  assign if_bad   = (|if_spm_addr[1:0])  | (|if_spm_addr[31:IDX_W+2]);
  assign mem_bad  = (|mem_spm_addr[1:0]) | (|mem_spm_addr[31:IDX_W+2]);
  assign run      = (state_q == ST_RUN);
  assign same_idx = (if_idx == mem_idx);

  // Only two legal writes to the same word conflict; MEM wins, IF waits
  assign if_wr_ok  = if_req  & ~if_bad  & ~if_spm_rw;
  assign mem_wr_ok = mem_req & ~mem_bad & ~mem_spm_rw;
  assign if_stall  = if_wr_ok & mem_wr_ok & same_idx;

  assign if_spm_rdy  = run & if_req & ~if_stall;
  assign mem_spm_rdy = run & mem_req;

  // Bad accesses are still accepted, but only produce an error pulse
  assign if_we  = if_spm_rdy  & ~if_bad  & ~if_spm_rw;
  assign if_re  = if_spm_rdy  & ~if_bad  &  if_spm_rw;
  assign if_er  = if_spm_rdy  &  if_bad;
  assign mem_we = mem_spm_rdy & ~mem_bad & ~mem_spm_rw;
  assign mem_re = mem_spm_rdy & ~mem_bad &  mem_spm_rw;
  assign mem_er = mem_spm_rdy &  mem_bad;

  // ---------------- read data selection ----------------
  logic [31:0] if_rd_data_d, mem_rd_data_d;

  // Read word for each port, optionally forwarding a colliding write
  always_comb begin
    if_rd_data_d  = mem_q[if_idx];
    mem_rd_data_d = mem_q[mem_idx];
`ifdef SPM_FWD_EN
    if (mem_we && same_idx) if_rd_data_d  = merge_be(mem_q[if_idx], mem_spm_wr_data, mem_spm_be);
    if (if_we  && same_idx) mem_rd_data_d = merge_be(mem_q[mem_idx], if_spm_wr_data, if_spm_be);
`endif
  end

  // Storage array: clear sweep during INIT, byte-enable writes in RUN
  always_ff @(posedge clk) begin
    if (!run) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (mem_we) mem_q[mem_idx] <= merge_be(mem_q[mem_idx], mem_spm_wr_data, mem_spm_be);
      if (if_we)  mem_q[if_idx]  <= merge_be(mem_q[if_idx],  if_spm_wr_data,  if_spm_be);
    end
  end

  // INIT/RUN sequencing and registered port outputs
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q        <= ST_INIT;
      cnt_q          <= '0;
      init_done_q    <= 1'b0;
      if_rd_data_q   <= '0;
      if_rd_vld_q    <= 1'b0;
      if_err_q       <= 1'b0;
      mem_rd_data_q  <= '0;
      mem_rd_vld_q   <= 1'b0;
      mem_err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (cnt_q == IDX_W'(DEPTH - 1)) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + IDX_W'(1);
          end
        end
        default: state_q <= ST_RUN;
      endcase

      if_rd_vld_q  <= if_re;
      if_err_q     <= if_er;
      mem_rd_vld_q <= mem_re;
      mem_err_q    <= mem_er;
      if (if_re)  if_rd_data_q  <= if_rd_data_d;
      if (mem_re) mem_rd_data_q <= mem_rd_data_d;
    end
  end

  assign if_spm_rd_data  = if_rd_data_q;
  assign if_spm_rd_vld   = if_rd_vld_q;
  assign if_spm_err      = if_err_q;
  assign mem_spm_rd_data = mem_rd_data_q;
  assign mem_spm_rd_vld  = mem_rd_vld_q;
  assign mem_spm_err     = mem_err_q;
  assign spm_init_done   = init_done_q;

endmodule

`default_nettype wire
